// File: rtl/aoc_pkg.sv
// Shared definitions for the list pair scorer.
// Holds the job state encoding, the default geometry constants and a small
// state-decode helper used by the top level.
package aoc_pkg;

  localparam int DEF_DEPTH = 1000;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SUMW  = 48;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SORT = 3'd2,
    S_DIST = 3'd3,
    S_SIM  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // A job is in flight from the first load cycle until the last SIM cycle.
  function automatic logic is_busy(input state_e s);
    logic b;
    case (s)
      S_LOAD, S_SORT, S_DIST, S_SIM: b = 1'b1;
      default:                       b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sort_bank.sv
// One list of the scorer: DEPTH x WIDTH storage with a write port for
// loading, a single compare-swap of entries [idx] and [idx+1] per cycle, a
// sticky "something swapped this pass" flag and two asynchronous read ports.
// Ports:
//   clk_i, rst_i          clock, async active-high reset (flag only)
//   wr_en_i/addr/data     load port
//   swap_en_i, swap_idx_i compare-swap enable and lower index
//   clr_swapped_i         clears the pass flag (wins over a same-cycle swap)
//   swap_now_o            this cycle's compare-swap exchanges the pair
//   swapped_o             a swap happened earlier in the current pass
//   rd_a/rd_b             two read ports
module sort_bank
  import aoc_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             swap_en_i,
  input  logic [AW-1:0]    swap_idx_i,
  input  logic             clr_swapped_i,
  output logic             swap_now_o,
  output logic             swapped_o,
  input  logic [AW-1:0]    rd_a_addr_i,
  output logic [WIDTH-1:0] rd_a_data_o,
  input  logic [AW-1:0]    rd_b_addr_i,
  output logic [WIDTH-1:0] rd_b_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             swapped_q;
  logic [AW-1:0]    hi_idx;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;

  assign hi_idx = swap_idx_i + AW'(1);
  assign lo_val = mem_q[swap_idx_i];
  assign hi_val = mem_q[hi_idx];
  // Strictly greater: equal neighbours stay put.
  assign swap_now_o = swap_en_i && (lo_val > hi_val);
  assign swapped_o  = swapped_q;

  assign rd_a_data_o = mem_q[rd_a_addr_i];
  assign rd_b_data_o = mem_q[rd_b_addr_i];

  // List storage: load writes or a compare-swap exchange; never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end else if (swap_now_o) begin
      mem_q[swap_idx_i] <= hi_val;
      mem_q[hi_idx]     <= lo_val;
    end else begin
      mem_q[wr_addr_i] <= mem_q[wr_addr_i];
    end
  end

  // Sticky per-pass swap flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      swapped_q <= 1'b0;
    end else if (clr_swapped_i) begin
      swapped_q <= 1'b0;
    end else if (swap_now_o) begin
      swapped_q <= 1'b1;
    end else begin
      swapped_q <= swapped_q;
    end
  end

endmodule

// File: rtl/list_pair_scorer.sv
// List pair scorer: loads up to DEPTH (left,right) pairs, bubble-sorts both
// lists in parallel, then accumulates the sorted-distance sum and the
// similarity sum, both modulo 2^SUMW with a sticky overflow flag.
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 begin a job (honoured in IDLE/DONE only)
//   in_valid/in_ready     pair handshake, ready only while loading
//   in_left/in_right      list elements, in_last marks the final pair
//   busy, done            job in flight / results valid (level)
//   dist_sum, sim_sum     results; ovf set if either sum wrapped
module list_pair_scorer
  import aoc_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SUMW  = DEF_SUMW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [SUMW-1:0]  dist_sum,
  output logic [SUMW-1:0]  sim_sum,
  output logic             ovf
);

  // IW holds counts 0..DEPTH, AW addresses 0..DEPTH-1.
  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Adder width wide enough to expose the carry out of SUMW.
  localparam int XW = ((SUMW > WIDTH) ? SUMW : WIDTH) + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   n_q, n_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [IW-1:0]   jrun_q, jrun_d;
  logic [IW-1:0]   pass_q, pass_d;
  logic [SUMW-1:0] dist_q, dist_d;
  logic [SUMW-1:0] sim_q, sim_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, busy_q, done_q;

  logic             wr_en, swap_en, clr_swapped;
  logic             l_swap_now, r_swap_now, l_swapped, r_swapped;
  logic             pass_swapped;
  logic [AW-1:0]    rd_a_addr, rd_b_addr;
  logic [WIDTH-1:0] l_rd_a, l_rd_b, r_rd_a, r_rd_b;
  logic [WIDTH-1:0] dist_le, dist_ri, sim_le, sim_ri, abs_diff;
  logic [XW-1:0]    dist_ext, sim_ext;

  // Port a always reads index i. Port b reads i during DIST and j during SIM,
  // so DIST takes left from port b / right from port a and SIM takes left
  // from port a / right from port b.
  assign rd_a_addr = i_q[AW-1:0];
  assign rd_b_addr = (state_q == S_SIM) ? j_q[AW-1:0] : i_q[AW-1:0];
  assign dist_le   = l_rd_b;
  assign dist_ri   = r_rd_a;
  assign sim_le    = l_rd_a;
  assign sim_ri    = r_rd_b;

  // Unsigned absolute difference without going through a signed subtract.
  assign abs_diff = (dist_le >= dist_ri) ? (dist_le - dist_ri) : (dist_ri - dist_le);
  assign dist_ext = XW'(dist_q) + XW'(abs_diff);
  assign sim_ext  = XW'(sim_q) + XW'(sim_le);

  // The pass decision must include the swap being made on its last cycle.
  assign pass_swapped = l_swapped | r_swapped | l_swap_now | r_swap_now;

  sort_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_left (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (n_q[AW-1:0]),
    .wr_data_i    (in_left),
    .swap_en_i    (swap_en),
    .swap_idx_i   (j_q[AW-1:0]),
    .clr_swapped_i(clr_swapped),
    .swap_now_o   (l_swap_now),
    .swapped_o    (l_swapped),
    .rd_a_addr_i  (rd_a_addr),
    .rd_a_data_o  (l_rd_a),
    .rd_b_addr_i  (rd_b_addr),
    .rd_b_data_o  (l_rd_b)
  );

  sort_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_right (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (n_q[AW-1:0]),
    .wr_data_i    (in_right),
    .swap_en_i    (swap_en),
    .swap_idx_i   (j_q[AW-1:0]),
    .clr_swapped_i(clr_swapped),
    .swap_now_o   (r_swap_now),
    .swapped_o    (r_swapped),
    .rd_a_addr_i  (rd_a_addr),
    .rd_a_data_o  (r_rd_a),
    .rd_b_addr_i  (rd_b_addr),
    .rd_b_data_o  (r_rd_b)
  );

  // Next-state, pointer and accumulator logic.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    i_d         = i_q;
    j_d         = j_q;
    jrun_d      = jrun_q;
    pass_d      = pass_q;
    dist_d      = dist_q;
    sim_d       = sim_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    swap_en     = 1'b0;
    clr_swapped = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          n_d     = '0;
          i_d     = '0;
          j_d     = '0;
          jrun_d  = '0;
          pass_d  = '0;
          dist_d  = '0;
          sim_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          n_d   = n_q + IW'(1);
          // Filling the last slot ends the list even without in_last.
          if (in_last || (n_q == IW'(DEPTH - 1))) begin
            i_d         = '0;
            j_d         = '0;
            pass_d      = IW'(1);
            clr_swapped = 1'b1;
            // A single pair is already sorted.
            state_d     = (n_q == '0) ? S_DIST : S_SORT;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_SORT: begin
        swap_en = 1'b1;
        if (j_q == (n_q - IW'(2))) begin
          if (!pass_swapped || (pass_q == (n_q - IW'(1)))) begin
            state_d = S_DIST;
            i_d     = '0;
          end else begin
            j_d         = '0;
            pass_d      = pass_q + IW'(1);
            clr_swapped = 1'b1;
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      S_DIST: begin
        dist_d = dist_ext[SUMW-1:0];
        ovf_d  = ovf_q | (|dist_ext[XW-1:SUMW]);
        if (i_q == (n_q - IW'(1))) begin
          state_d = S_SIM;
          i_d     = '0;
          j_d     = '0;
          jrun_d  = '0;
        end else begin
          i_d = i_q + IW'(1);
        end
      end

      S_SIM: begin
        if (i_q == n_q) begin
          state_d = S_DONE;
        end else if ((j_q == n_q) || (sim_ri > sim_le)) begin
          // Next left element restarts at the first right entry not below
          // the current one, so runs of equal left values rescan it.
          i_d = i_q + IW'(1);
          j_d = jrun_q;
        end else if (sim_ri < sim_le) begin
          j_d    = j_q + IW'(1);
          jrun_d = j_q + IW'(1);
        end else begin
          sim_d = sim_ext[SUMW-1:0];
          ovf_d = ovf_q | (|sim_ext[XW-1:SUMW]);
          j_d   = j_q + IW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointers, accumulators and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      jrun_q     <= '0;
      pass_q     <= '0;
      dist_q     <= '0;
      sim_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      jrun_q     <= jrun_d;
      pass_q     <= pass_d;
      dist_q     <= dist_d;
      sim_q      <= sim_d;
      ovf_q      <= ovf_d;
      in_ready_q <= (state_d == S_LOAD);
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dist_sum = dist_q;
  assign sim_sum  = sim_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/list_pair_scorer.md
LIST_PAIR_SCORER -- requirements
Module: list_pair_scorer

Interface
REQ-001 SHALL have parameter DEPTH, default 1000: maximum pairs per list.
REQ-002 SHALL have parameter WIDTH, default 32: element width, unsigned.
REQ-003 SHALL have parameter SUMW, default 48: accumulator and result width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a job; honoured only in IDLE or DONE.
REQ-008 in_valid  in  1  input pair valid.
REQ-009 in_ready  out  1  high only in LOAD.
REQ-010 in_left, in_right  in  WIDTH  left and right list elements.
REQ-011 in_last  in  1  marks the final pair of the job.
REQ-012 busy  out  1  high in LOAD, SORT, DIST and SIM.
REQ-013 done  out  1  level; high in DONE.
REQ-014 dist_sum  out  SUMW  sum of |left[k]-right[k]| over both sorted lists.
REQ-015 sim_sum  out  SUMW  sum of left[i] times the count of right elements equal to left[i].
REQ-016 ovf  out  1  sticky; set if either accumulator carries out of SUMW.

Function
REQ-017 States SHALL be IDLE, LOAD, SORT, DIST, SIM, DONE; start moves IDLE/DONE->LOAD next cycle, clears n, accumulators, ovf.
REQ-018 Transfer SHALL occur when in_valid&&in_ready; pair stored at index n, n increments.
REQ-019 LOAD SHALL exit to SORT on a transfer with in_last, or on the transfer filling index DEPTH-1 (in_last implied).
REQ-020 SORT SHALL bubble-sort both lists ascending in parallel: one compare-swap of [j],[j+1] per list per cycle, j=0..n-2 per pass.
REQ-021 SORT SHALL end when a pass makes no swap in either list, or after n-1 passes; n=1 skips SORT (zero cycles).
REQ-022 Equal elements SHALL NOT be swapped.
REQ-023 DIST SHALL take exactly n cycles, adding |le[i]-ri[i]| for i=0..n-1, computed without signed wrap.
REQ-024 SIM SHALL use pointers i, j, jrun (all 0 at entry), one action per cycle:
REQ-025 -- ri[j]<le[i]: j++, jrun=j+1.
REQ-026 -- ri[j]==le[i]: sim += le[i], j++.
REQ-027 -- j==n or ri[j]>le[i]: i++, j=jrun.
REQ-028 -- i==n: go to DONE.
REQ-029 Accumulators SHALL wrap modulo 2^SUMW on carry-out and set ovf.
REQ-030 dist_sum, sim_sum, ovf SHALL hold in DONE until the next accepted start.
REQ-031 start in LOAD/SORT/DIST/SIM SHALL be ignored; in_valid outside LOAD SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE and clear in_ready, busy, done, ovf, dist_sum, sim_sum, n and all pointers; list storage is not reset.
REQ-033 rst asserted mid-job SHALL abandon the job; the next start behaves as from power-up.

Structure
REQ-034 Shared package aoc_pkg SHALL hold the state enum and default WIDTH, SUMW, DEPTH constants.
REQ-035 Sub-module sort_bank (DEPTH x WIDTH storage, compare-swap at index j, swapped flag, two read ports) SHALL be instantiated twice; state machine, pointers and accumulators stay in list_pair_scorer.

Verification
REQ-036 Pairs (3,4)(4,3)(2,5)(1,3)(3,9)(3,3), in_last on 6th -> done, dist_sum=11, sim_sum=31, ovf=0.
REQ-037 Single pair (5,5) with in_last -> SORT skipped, DIST 1 cycle, dist_sum=0, sim_sum=5.
REQ-038 Pre-sorted (1,1)(2,2)(3,3) -> SORT exactly 2 cycles (one pass), dist_sum=0, sim_sum=6.
REQ-039 SUMW=8, pairs (200,0)(200,0) -> dist_sum=144, ovf=1.
REQ-040 DEPTH=4, 4 pairs without in_last -> in_ready drops after 4th transfer, job completes normally.
REQ-041 rst pulse mid-SORT -> IDLE, outputs 0; new job with REQ-036 data -> dist_sum=11, sim_sum=31.
